// File: rtl/ofm_writeback_scheduler.sv
// OFM write-back scheduler: snapshots the activated channels of each output pixel
// and streams them as packed 32-bit words into the OFM BRAM at HWC addresses.
module ofm_writeback_scheduler #(
  parameter int NUM_PE    = 16,
  parameter int DATA_W    = 8,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               OFM_W,
  input  logic [7:0]               OFM_C,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [NUM_PE-1:0]        valid,
  input  logic [NUM_PE*DATA_W-1:0] ofm_in,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WORD_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [1:0]               dbg_state
);

  localparam int SNAP_W      = NUM_PE * DATA_W;
  localparam int CH_PER_WORD = WORD_W / DATA_W;
  localparam int MAX_NW      = NUM_PE / CH_PER_WORD;
  localparam int NW_W        = $clog2(MAX_NW + 1);
  localparam int K_W         = (MAX_NW > 1) ? $clog2(MAX_NW) : 1;
  localparam int PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W       = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SNAP_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [NW_W-1:0]   nw;
  } entry_t;

  state_t            state;
  logic [7:0]        cfg_c;
  logic [ADDR_W-1:0] cfg_base;
  logic [15:0]       npix_m1;
  logic [7:0]        last_tile;
  logic [15:0]       pix;
  logic [7:0]        tile;
  logic              all_captured;

  entry_t            fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic [SNAP_W-1:0] cur_data;
  logic [NW_W-1:0]   cur_nw;
  logic [K_W-1:0]    k;

  // Handshake: valid/ofm_in is an unacknowledged strobe (no ready); a snapshot that
  // finds no room is dropped and flagged on overflow. wr_en is likewise fire-and-forget.
  logic              capture;
  logic [11:0]       tile_ch;
  logic [11:0]       rem_ch;
  logic [23:0]       pix_prod;
  entry_t            cap_entry;
  entry_t            next_entry;
  logic              last_now;
  logic              writer_free;
  logic              pop;
  logic              bypass;
  logic              accept;
  logic              push;
  logic              drop;
  logic [K_W-1:0]    k_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dbg_state = state;

  always_comb begin
    capture  = (state == S_RUN) && (|valid) && !all_captured;
    tile_ch  = 12'(tile) * 12'(NUM_PE);
    rem_ch   = 12'(cfg_c) - tile_ch;
    pix_prod = 24'(pix) * 24'(cfg_c);

    cap_entry.data = ofm_in;
    cap_entry.addr = cfg_base + ADDR_W'(pix_prod / 24'(CH_PER_WORD))
                   + ADDR_W'(tile_ch / 12'(CH_PER_WORD));
    // Only the last tile can be partial; it stops at the last real channel group.
    cap_entry.nw   = (rem_ch >= 12'(NUM_PE)) ? NW_W'(MAX_NW)
                                             : NW_W'(rem_ch / 12'(CH_PER_WORD));

    last_now    = wr_en && ((NW_W'(k) + NW_W'(1)) == cur_nw);
    writer_free = !wr_en || last_now;
    pop         = writer_free && (count != '0);
    bypass      = writer_free && (count == '0) && capture;
    accept      = capture && ((count < CNT_W'(BUF_DEPTH)) || pop);
    push        = accept && !bypass;
    drop        = capture && !accept;
    next_entry  = pop ? fifo_mem[rd_ptr] : cap_entry;
    k_next      = k + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cfg_c        <= '0;
      cfg_base     <= '0;
      npix_m1      <= '0;
      last_tile    <= '0;
      pix          <= '0;
      tile         <= '0;
      all_captured <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      cur_data     <= '0;
      cur_nw       <= '0;
      k            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (start) begin
            cfg_c        <= OFM_C;
            cfg_base     <= base_addr;
            npix_m1      <= 16'(OFM_W) * 16'(OFM_W) - 16'd1;
            last_tile    <= 8'((9'(OFM_C) + 9'(NUM_PE - 1)) / 9'(NUM_PE) - 9'd1);
            pix          <= '0;
            tile         <= '0;
            all_captured <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            state        <= S_RUN;
          end
        end

        S_RUN: begin
          // Dropped snapshots still advance p/t so later pixels keep their addresses.
          if (capture) begin
            if (pix == npix_m1) begin
              pix <= '0;
              if (tile == last_tile) all_captured <= 1'b1;
              else                   tile <= tile + 8'd1;
            end else begin
              pix <= pix + 16'd1;
            end
          end
          if (drop) overflow <= 1'b1;

          if (push) begin
            fifo_mem[wr_ptr] <= cap_entry;
            wr_ptr           <= ptr_inc(wr_ptr);
          end
          case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase

          if (writer_free) begin
            if (pop || bypass) begin
              cur_data <= next_entry.data;
              cur_nw   <= next_entry.nw;
              k        <= '0;
              wr_en    <= 1'b1;
              wr_addr  <= next_entry.addr;
              wr_data  <= next_entry.data[WORD_W-1:0];
              if (pop) rd_ptr <= ptr_inc(rd_ptr);
            end else begin
              wr_en <= 1'b0;
            end
          end else begin
            k       <= k_next;
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_data <= cur_data[k_next*WORD_W +: WORD_W];
          end

          if (all_captured && (count == '0) && writer_free) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          wr_en <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writeback_scheduler.sv
// Bench for ofm_writeback_scheduler: directed scenarios plus randomized jobs checked
// against a transaction-level model of capture acceptance, write timing and addressing.
module tb_ofm_writeback_scheduler;
  localparam int NUM_PE = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        OFM_W = '0;
  logic [7:0]        OFM_C = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [NUM_PE-1:0] valid = '0;
  logic [127:0]      ofm_in = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [1:0]        dbg_state;

  ofm_writeback_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .OFM_W(OFM_W), .OFM_C(OFM_C),
    .base_addr(base_addr), .valid(valid), .ofm_in(ofm_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard state
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_data_q[$];
  int           exp_cyc_q[$];
  logic [31:0]  obs_addr_q[$];
  logic [31:0]  obs_data_q[$];
  int           obs_cyc_q[$];
  int           cap_cyc_q[$];
  logic [127:0] cap_dat_q[$];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         ovf_at_done = 1'b0;
  bit           exp_ovf;
  int           exp_done_cyc;
  int           m_w, m_c;
  logic [31:0]  m_base;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr_q.push_back(wr_addr);
      obs_data_q.push_back(wr_data);
      obs_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc    = cyc;
      ovf_at_done = overflow;
    end
  end

  // driver tasks
  function automatic logic [127:0] rand_snap();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_addr_q.delete(); obs_data_q.delete(); obs_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int w, input int c, input logic [31:0] base);
    @(negedge clk);
    OFM_W = 8'(w); OFM_C = 8'(c); base_addr = base; start = 1'b1;
    m_w = w; m_c = c; m_base = base;
    cap_cyc_q.delete(); cap_dat_q.delete();
    clear_obs();
    @(negedge clk);
    start = 1'b0;
    OFM_W = 8'($urandom); OFM_C = 8'($urandom); base_addr = $urandom;
  endtask

  task automatic capture(input logic [127:0] d);
    valid  = NUM_PE'($urandom_range(1, 65535));
    ofm_in = d;
    cap_cyc_q.push_back(cyc);
    cap_dat_q.push_back(d);
    @(negedge clk);
    valid  = '0;
    ofm_in = rand_snap();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference model: walks captures in order. Pixel/tile come from the capture
  // index, a capture is kept when fewer than two kept entries are still waiting
  // to begin writing, and each kept entry writes back-to-back after its predecessor.
  task automatic build_expected();
    int npix, ntiles, total, last_end, waiting, s, nw, p, t;
    int acc_s[$];
    logic [127:0] snap;
    exp_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
    exp_ovf  = 1'b0;
    last_end = -1;
    npix   = m_w * m_w;
    ntiles = (m_c + 15) / 16;
    total  = npix * ntiles;
    for (int i = 0; i < cap_cyc_q.size() && i < total; i++) begin
      p = i % npix;
      t = i / npix;
      waiting = 0;
      foreach (acc_s[j]) if (acc_s[j] > cap_cyc_q[i] + 1) waiting++;
      if (waiting >= 2) begin
        exp_ovf = 1'b1;
        continue;
      end
      s  = (cap_cyc_q[i] + 1 > last_end + 1) ? cap_cyc_q[i] + 1 : last_end + 1;
      nw = (m_c - 16 * t) / 4;
      if (nw > 4) nw = 4;
      snap = cap_dat_q[i];
      for (int k = 0; k < nw; k++) begin
        exp_q.push_back(m_base + 32'((p * m_c + 16 * t) / 4 + k));
        exp_data_q.push_back(snap[32*k +: 32]);
        exp_cyc_q.push_back(s + k);
      end
      last_end = s + nw - 1;
      acc_s.push_back(s);
    end
    exp_done_cyc = last_end + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_cmp++;
    if ({wr_en, busy, done, overflow} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: wr_en/busy/done/overflow = %b, required 0000", {wr_en, busy, done, overflow});
    end
    reset = 1'b0;
    clear_obs();
    repeat (3) capture(rand_snap());
    idle(5);
    n_cmp++;
    if (obs_addr_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_valid_ignored: %0d writes busy=%b, required 0 writes busy=0", obs_addr_q.size(), busy);
    end
  endtask

  task automatic test_single_tile();
    bit ok;
    do_start(2, 16, 32'h100);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL t1_busy: busy=%b after start, required 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      capture(rand_snap());
      idle(7);
    end
    wait_done(200, ok);
    build_expected();
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL t1_done_timeout: done not seen, required within 200 cycles"); end
    n_cmp++;
    if (obs_addr_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL t1_count: %0d writes, required %0d", obs_addr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i] || obs_addr_q[i] !== 32'h100 + 32'(i)) begin
        n_bad++;
        $display("FAIL t1_write[%0d]: addr %h data %h cyc %0d, required addr %h data %h cyc %0d", i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != exp_done_cyc || ovf_at_done !== exp_ovf) begin
      n_bad++; $display("FAIL t1_done: count %0d cyc %0d ovf %b, required 1 cyc %0d ovf %b", done_cnt, done_cyc, ovf_at_done, exp_done_cyc, exp_ovf);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_end: busy=%b, required 0", busy); end
  endtask

  task automatic test_packing();
    bit ok;
    logic [31:0] pk[4];
    pk[0] = 32'h03020100; pk[1] = 32'h07060504; pk[2] = 32'h0B0A0908; pk[3] = 32'h0F0E0D0C;
    do_start(1, 16, 32'h40);
    capture(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || obs_data_q.size() != 4) begin
      n_bad++; $display("FAIL t3_count: done=%0d writes=%0d, required done and 4 writes", ok, obs_data_q.size());
    end
    for (int i = 0; i < 4 && i < obs_data_q.size(); i++) begin
      n_cmp++;
      if (obs_data_q[i] !== pk[i] || obs_addr_q[i] !== 32'h40 + 32'(i)) begin
        n_bad++; $display("FAIL t3_word[%0d]: addr %h data %h, required addr %h data %h", i, obs_addr_q[i], obs_data_q[i], 32'h40 + 32'(i), pk[i]);
      end
    end
  endtask

  task automatic test_multi_tile();
    bit ok;
    do_start(1, 24, 32'h500);
    capture(rand_snap());
    idle(8);
    capture(rand_snap());
    wait_done(200, ok);
    build_expected();
    n_cmp++;
    if (!ok || obs_addr_q.size() != 6 || exp_q.size() != 6) begin
      n_bad++; $display("FAIL t2_count: done=%0d writes=%0d, required done and 6 writes", ok, obs_addr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i] || obs_addr_q[i] !== 32'h500 + 32'(i)) begin
        n_bad++;
        $display("FAIL t2_write[%0d]: addr %h data %h cyc %0d, required addr %h data %h cyc %0d", i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != exp_done_cyc) begin
      n_bad++; $display("FAIL t2_done: count %0d cyc %0d, required 1 cyc %0d", done_cnt, done_cyc, exp_done_cyc);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_start(3, 16, 32'h200);
    repeat (4) capture(rand_snap());
    idle(12);
    for (int i = 0; i < 5; i++) begin
      capture(rand_snap());
      idle(5);
    end
    wait_done(400, ok);
    build_expected();
    n_cmp++;
    if (!ok || obs_addr_q.size() != exp_q.size() || obs_addr_q.size() != 32) begin
      n_bad++; $display("FAIL t4_count: done=%0d writes=%0d, required done and 32 writes", ok, obs_addr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
        n_bad++;
        $display("FAIL t4_write[%0d]: addr %h data %h cyc %0d, required addr %h data %h cyc %0d", i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
    n_cmp++;
    if (obs_addr_q.size() > 12 && obs_addr_q[12] !== 32'h210) begin
      n_bad++; $display("FAIL t4_pixel4_addr: %h, required 00000210", obs_addr_q[12]);
    end
    n_cmp++;
    if (overflow !== 1'b1 || ovf_at_done !== 1'b1 || exp_ovf != 1'b1) begin
      n_bad++; $display("FAIL t4_overflow: now %b at done %b, required 1", overflow, ovf_at_done);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int bad_addr;
    do_start(2, 16, 32'h400);
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL t6_ovf_cleared: overflow=%b after start, required 0", overflow); end
    capture(rand_snap());
    start = 1'b1; base_addr = 32'h900; OFM_C = 8'd32; OFM_W = 8'd1;
    capture(rand_snap());
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle(6);
      capture(rand_snap());
    end
    wait_done(300, ok);
    build_expected();
    bad_addr = 0;
    foreach (obs_addr_q[i]) if (obs_addr_q[i] < 32'h400 || obs_addr_q[i] > 32'h40F) bad_addr++;
    n_cmp++;
    if (!ok || obs_addr_q.size() != 16 || bad_addr != 0) begin
      n_bad++; $display("FAIL t6_base_kept: done=%0d writes=%0d stray=%0d, required done, 16 writes, 0 stray", ok, obs_addr_q.size(), bad_addr);
    end
    for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
      n_cmp++;
      if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
        n_bad++;
        $display("FAIL t6_write[%0d]: addr %h data %h cyc %0d, required addr %h data %h cyc %0d", i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_q[i], exp_data_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_start(2, 16, 32'h300);
    repeat (4) capture(rand_snap());
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (wr_en === 1'b1 && wr_addr === 32'h306) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found || overflow !== 1'b1) begin
      n_bad++; $display("FAIL t5_setup: word k=2 seen=%0d overflow=%b, required 1 and 1", found, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wr_en, busy, overflow, done} !== 4'b0000) begin
      n_bad++; $display("FAIL t5_abort: wr_en/busy/overflow/done = %b, required 0000", {wr_en, busy, overflow, done});
    end
    reset = 1'b0;
    clear_obs();
    repeat (3) capture(rand_snap());
    idle(10);
    n_cmp++;
    if (obs_addr_q.size() != 0 || busy !== 1'b0 || done_cnt != 0) begin
      n_bad++; $display("FAIL t5_quiet: writes %0d busy %b dones %0d, required 0 0 0", obs_addr_q.size(), busy, done_cnt);
    end
  endtask

  task automatic test_random();
    bit ok;
    int w, c, total;
    for (int j = 0; j < 8; j++) begin
      w = $urandom_range(1, 3);
      c = 4 * $urandom_range(1, 12);
      do_start(w, c, $urandom);
      total = w * w * ((c + 15) / 16) + $urandom_range(0, 2);
      for (int i = 0; i < total; i++) begin
        capture(rand_snap());
        idle($urandom_range(0, 5));
      end
      wait_done(3000, ok);
      build_expected();
      n_cmp++;
      if (!ok || obs_addr_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rnd%0d_count: done=%0d writes=%0d, required done and %0d writes", j, ok, obs_addr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_addr_q.size(); i++) begin
        n_cmp++;
        if (obs_addr_q[i] !== exp_q[i] || obs_data_q[i] !== exp_data_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_write[%0d]: addr %h data %h cyc %0d, required addr %h data %h cyc %0d", j, i, obs_addr_q[i], obs_data_q[i], obs_cyc_q[i], exp_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
      n_cmp++;
      if (done_cnt != 1 || done_cyc != exp_done_cyc || ovf_at_done !== exp_ovf) begin
        n_bad++; $display("FAIL rnd%0d_done: count %0d cyc %0d ovf %b, required 1 cyc %0d ovf %b", j, done_cnt, done_cyc, ovf_at_done, exp_done_cyc, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_packing();
    test_multi_tile();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
